// File: rtl/core_data_mem.sv
// Wait-state data memory with a Req/Ready handshake and per-byte write lanes.
// Optional macro CORE_DATA_MEM_BOUNDS_CHECK_EN adds an Err output and disables address aliasing.
module core_data_mem #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Req,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] WriteEnable,
    output logic [DATA_W-1:0]   ReadData,
`ifdef CORE_DATA_MEM_BOUNDS_CHECK_EN
    output logic                Err,
`endif
    output logic                Ready,
    output logic                Busy
);
    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [LANES-1:0]    we_q, we_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                enter;
    logic [ADDR_W-1:0]   acc_addr;
    logic [LANES-1:0]    acc_we;
    logic                acc_ok;
    logic                wr_ok;

`ifdef CORE_DATA_MEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    assign acc_ok = ({1'b0, acc_addr} < DEPTH_L);
    assign wr_ok  = ({1'b0, addr_q} < DEPTH_L);
    assign Err    = err_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr_q[ADDR_W-1:IDX_W], acc_addr[ADDR_W-1:IDX_W], err_q};
    assign acc_ok = 1'b1;
    assign wr_ok  = 1'b1;
`endif

    // The read is captured on entry to ACCESS so ReadData is already valid in the Ready cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        busy_d   = busy_q;
        err_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        enter    = 1'b0;
        acc_addr = addr_q;
        acc_we   = we_q;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    addr_d   = Address;
                    wdata_d  = WriteData;
                    we_d     = WriteEnable;
                    busy_d   = 1'b1;
                    acc_addr = Address;
                    acc_we   = WriteEnable;
                    if (WAIT_STATES == 0) begin
                        enter = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) enter = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (enter) begin
            state_d = S_ACCESS;
            ready_d = 1'b1;
            err_d   = ~acc_ok;
            if (acc_we == '0)
                rdata_d = acc_ok ? mem[acc_addr[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
    end

    // Write commits at the end of the ACCESS cycle; a reset before then drops it.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && wr_ok) begin
            for (int l = 0; l < LANES; l++) begin
                if (we_q[l]) mem[addr_q[IDX_W-1:0]][l*8 +: 8] <= wdata_q[l*8 +: 8];
            end
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_core_data_mem.sv
// Directed bench for core_data_mem at default parameters (16-bit, 256 words, 2 wait states).
module tb_core_data_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Req = 1'b0;
    logic [15:0] Address = '0;
    logic [15:0] WriteData = '0;
    logic [1:0]  WriteEnable = '0;
    logic [15:0] ReadData;
    logic        Ready;
    logic        Busy;
`ifdef CORE_DATA_MEM_BOUNDS_CHECK_EN
    logic        Err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    core_data_mem dut (
        .clk(clk), .rst(rst), .Req(Req), .Address(Address), .WriteData(WriteData),
        .WriteEnable(WriteEnable), .ReadData(ReadData),
`ifdef CORE_DATA_MEM_BOUNDS_CHECK_EN
        .Err(Err),
`endif
        .Ready(Ready), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; reports cycles to Ready, Busy-high samples and Err at Ready.
    task automatic access(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] we,
                          output int lat, output int bcnt, output logic err);
        Address = a; WriteData = wd; WriteEnable = we; Req = 1'b1;
        tick();
        Req = 1'b0; Address = 16'hFFFF; WriteData = 16'h0; WriteEnable = 2'b00;
        lat = 1; bcnt = Busy ? 1 : 0;
        while (!Ready && lat < 20) begin
            tick();
            lat++;
            if (Busy) bcnt++;
        end
        if (!Ready) check("ready_timeout", 32'(lat), 32'd3);
`ifdef CORE_DATA_MEM_BOUNDS_CHECK_EN
        err = Err;
`else
        err = 1'b0;
`endif
        tick();
    endtask

    int   lat, bcnt, rdy_cnt, rise_cnt;
    int   rise_at [3];
    logic err, prev_busy;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        check("rst_readdata", 32'(ReadData), 32'h0);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        rst = 1'b0;
        tick();

        access(16'h0003, 16'h0, 2'b00, lat, bcnt, err);
        check("read_latency", 32'(lat), 32'd3);
        check("read_busy_cycles", 32'(bcnt), 32'd3);
        check("post_ready_low", 32'(Ready), 32'd0);
        check("post_busy_low", 32'(Busy), 32'd0);

        access(16'h0010, 16'hBEEF, 2'b11, lat, bcnt, err);
        check("write_latency", 32'(lat), 32'd3);
        access(16'h0010, 16'h0, 2'b00, lat, bcnt, err);
        check("read_beef", 32'(ReadData), 32'hBEEF);

        access(16'h0010, 16'h1234, 2'b01, lat, bcnt, err);
        check("write_holds_rdata", 32'(ReadData), 32'hBEEF);
        access(16'h0010, 16'h0, 2'b00, lat, bcnt, err);
        check("byte_lane_be34", 32'(ReadData), 32'hBE34);

        access(16'h0005, 16'h0077, 2'b11, lat, bcnt, err);
        access(16'h0105, 16'h00AA, 2'b11, lat, bcnt, err);
`ifdef CORE_DATA_MEM_BOUNDS_CHECK_EN
        check("oob_err", 32'(err), 32'd1);
        access(16'h0005, 16'h0, 2'b00, lat, bcnt, err);
        check("oob_no_write", 32'(ReadData), 32'h0077);
        check("inrange_no_err", 32'(err), 32'd0);
`else
        check("wrap_no_err", 32'(err), 32'd0);
        access(16'h0005, 16'h0, 2'b00, lat, bcnt, err);
        check("wrap_read", 32'(ReadData), 32'h00AA);
`endif

        // Req held high: accepts every 4 cycles, one Ready each
        Address = 16'h0010; WriteEnable = 2'b00; Req = 1'b1;
        rdy_cnt = 0; rise_cnt = 0; prev_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (Ready) rdy_cnt++;
            if (Busy && !prev_busy) begin
                if (rise_cnt < 3) rise_at[rise_cnt] = i;
                rise_cnt++;
            end
            prev_busy = Busy;
        end
        Req = 1'b0;
        tick();
        check("held_req_readies", 32'(rdy_cnt), 32'd3);
        check("held_req_accepts", 32'(rise_cnt), 32'd3);
        check("accept_gap_1", 32'(rise_at[1] - rise_at[0]), 32'd4);
        check("accept_gap_2", 32'(rise_at[2] - rise_at[1]), 32'd4);
        check("held_req_rdata", 32'(ReadData), 32'hBE34);

        // Reset during WAIT abandons the write
        access(16'h0020, 16'h1111, 2'b11, lat, bcnt, err);
        Address = 16'h0020; WriteData = 16'h5555; WriteEnable = 2'b11; Req = 1'b1;
        tick();
        Req = 1'b0;
        check("midreset_accepted", 32'(Busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_ready", 32'(Ready), 32'd0);
        check("midreset_rdata", 32'(ReadData), 32'h0);
        tick();
        rst = 1'b0;
        rdy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Ready) rdy_cnt++;
        end
        check("midreset_no_ready", 32'(rdy_cnt), 32'd0);
        access(16'h0020, 16'h0, 2'b00, lat, bcnt, err);
        check("midreset_mem_kept", 32'(ReadData), 32'h1111);
        access(16'h0010, 16'h0, 2'b00, lat, bcnt, err);
        check("mem_retained_reset", 32'(ReadData), 32'hBE34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/core_data_mem.md
Name: core_data_mem

Overview:
- Parametrised, wait-state-capable data memory that serves the 16-bit core's load/store port (Address, WriteData, WriteEnable, ReadData).
- Successor to the fixed single-cycle memory: configurable width, depth and access latency, per-byte write lanes, and a Req/Ready handshake so the core can stall on slow memory.
- Sits between the core and on-chip RAM; it is also used as the memory model in core-level benches.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 16, address width in bits (word addresses).
- DEPTH, 256, number of words; power of two, DEPTH <= 2**ADDR_W.
- WAIT_STATES, 2, extra cycles inserted before each access completes; 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Req  in  1  access request; sampled only in IDLE.
- Address  in  ADDR_W  word address.
- WriteData  in  DATA_W  write data.
- WriteEnable  in  DATA_W/8  byte-lane write enables; all zero means read.
- ReadData  out  DATA_W  registered read data.
- Ready  out  1  one-cycle pulse marking access completion.
- Busy  out  1  high from request acceptance until the Ready cycle, inclusive.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE; ReadData=0, Ready=0, Busy=0, wait counter=0. Memory array contents are not cleared and are retained across reset.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - On Req=1, latch Address, WriteData and WriteEnable, and set Busy=1 from the next cycle.
  - If WAIT_STATES=0, go to ACCESS; otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; when it reaches 0, go to ACCESS. The latched request is unaffected by input changes.
- ACCESS:
  - Ready=1 for exactly this cycle.
  - Write (any WriteEnable bit set): update only the enabled byte lanes of mem[latched addr]; ReadData holds its previous value.
  - Read (WriteEnable=0): ReadData = mem[latched addr], valid in the Ready cycle and held until the next read completes.
  - Next state is IDLE.
- Latency: Req sampled at edge N gives Ready high in cycle N+1+WAIT_STATES. Minimum request spacing is WAIT_STATES+2 cycles.
- Req in any non-IDLE state, including the Ready cycle, is ignored. The requester must hold or re-issue Req until it is accepted (Busy rises).
- Address mapping: only Address[log2(DEPTH)-1:0] indexes memory; higher bits are ignored, so addresses alias (wrap) modulo DEPTH.
- Reset mid-access: the in-flight access is abandoned and no write is committed. Ready never pulses for it.
- A write followed by a read to the same address returns the newly written data, with no bypass hazard, because accesses are serialised.

Optional Feature:
- Macro: CORE_DATA_MEM_BOUNDS_CHECK_EN.
- When defined:
  - Adds an output port Err (1 bit). Err pulses together with Ready when latched Address >= DEPTH.
  - Such a write is suppressed, and such a read returns ReadData=0. Aliasing is disabled.
  - Err resets to 0.
- When undefined: no Err port, and addresses wrap modulo DEPTH as described above.

Test Plan:
- Reset then read: assert rst, release, then Req read at addr 0x0003 with WAIT_STATES=2. Ready must pulse exactly 3 cycles after acceptance, and Busy must be high for 3 cycles.
- Write then read: write 0xBEEF to addr 0x0010 with WriteEnable=2'b11, then read addr 0x0010 -> ReadData=0xBEEF.
- Byte lanes: addr 0x0010 holds 0xBEEF; write 0x1234 with WriteEnable=2'b01; read back -> 0xBE34.
- Ignored request: hold Req high continuously. Requests must be accepted only every WAIT_STATES+2 = 4 cycles, with exactly one Ready per accepted request.
- Wrap and bounds: with DEPTH=256, write 0x00AA to addr 0x0105 and read addr 0x0005 -> 0x00AA. With CORE_DATA_MEM_BOUNDS_CHECK_EN, the same write gives Err=1 with Ready, and addr 0x0005 is unchanged.
- Reset mid-access: issue a write of 0x5555 to addr 0x0020 and assert rst during WAIT. Ready must not pulse, and a later read of 0x0020 returns its prior value.
